// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: loader FSM state encoding, stream framing constants and derived widths.
package loader_pkg;

    // Loader FSM states. FINISH and ERROR are terminal until reset.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN0   = 3'd1,
        LEN1   = 3'd2,
        WORD   = 3'd3,
        WRITE  = 3'd4,
        FINISH = 3'd5,
        ERROR  = 3'd6
    } loader_state_t;

    // Stream framing: little-endian word-count header, then 4-byte words LSB first.
    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;

    localparam int LEN_W      = 8 * HDR_BYTES;
    localparam int BYTE_IDX_W = $clog2(WORD_BYTES);

endpackage

// File: rtl/instr_mem_loader_if.sv
// Bus interfaces for the loader: inbound byte stream and instruction-memory write port.
// Latency: n/a (wiring only).
// Backpressure: byte stream uses valid/ready, write port is a fire-and-forget strobe.
//
// byte_stream_if : byte_dat/byte_vld from the source, byte_rdy from the loader.
// imem_wr_if     : mem_waddr/mem_wdata/mem_wr from the loader to the instruction memory.
interface byte_stream_if;
    logic [7:0] byte_dat;
    logic       byte_vld;
    logic       byte_rdy;

    // Source side of the stream.
    modport master (
        output byte_dat,
        output byte_vld,
        input  byte_rdy
    );

    // Sink side of the stream (the loader).
    modport slave (
        input  byte_dat,
        input  byte_vld,
        output byte_rdy
    );
endinterface

interface imem_wr_if;
    logic [63:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_wr;

    // Writer side (the loader).
    modport master (
        output mem_waddr,
        output mem_wdata,
        output mem_wr
    );

    // Memory side.
    modport slave (
        input  mem_waddr,
        input  mem_wdata,
        input  mem_wr
    );
endinterface

// File: rtl/instr_mem_loader_byte_packer.sv
// Packs an 8-bit byte stream into 32-bit words, lane 0 first.
// Latency: byte visible in word_o the cycle after load_i; full_o is combinational.
// Backpressure: none; the caller gates load_i with its own handshake.
//
// Ports: clk_i, rst_ni (sync, active-low), clr_i (restart at lane 0),
//        load_i (write byte_i into the current lane), byte_i,
//        word_o (packed word, held until overwritten), full_o (this load completes a word).
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        load_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        full_o
);

    logic [31:0]           word_q, word_d;
    logic [BYTE_IDX_W-1:0] idx_q,  idx_d;

    localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(WORD_BYTES - 1);

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (clr_i) begin
            // Only the lane pointer restarts; the data stays stable so a
            // concurrent memory write still sees the completed word.
            idx_d = '0;
        end else if (load_i) begin
            word_d[8*idx_q +: 8] = byte_i;
            idx_d                = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

    assign word_o = word_q;
    assign full_o = load_i && !clr_i && (idx_q == LAST_IDX);

endmodule

// File: rtl/instr_mem_loader.sv
// Boot loader: byte stream -> 32-bit words -> instruction memory, then releases the core.
// Latency: 5 cycles min per word (4 byte transfers + 1 write cycle); core released the edge after the last write.
// Backpressure: byte_rdy depends only on FSM state (LEN0/LEN1/WORD); deasserted during writes and in terminal states.
//
// Ports: clk_i, rst_ni (sync, active-low), start_i (begin a load from IDLE),
//        byte_if (stream sink), mem_if (instruction-memory write port),
//        cpu_hold_o (core reset request), done_o (sticky, image written), err_o (sticky, header too long).
module instr_mem_loader
    import loader_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = 64'h0,
    parameter int          MAX_WORDS = 1024,
    parameter logic [63:0] ADDR_STEP = 64'd4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    byte_stream_if.slave  byte_if,
    imem_wr_if.master     mem_if,
    output logic          cpu_hold_o,
    output logic          done_o,
    output logic          err_o
);

    localparam logic [31:0] MAX_WORDS_U = 32'(MAX_WORDS);

    loader_state_t     state_q,  state_d;
    logic [63:0]       waddr_q,  waddr_d;
    logic [LEN_W-1:0]  remain_q, remain_d;
    logic [7:0]        len_lo_q, len_lo_d;

    logic              byte_rdy;
    logic              xfer;
    logic [LEN_W-1:0]  len_full;
    logic              pk_load;
    logic              pk_clr;
    logic              pk_full;
    logic [31:0]       pk_word;

    // Ready is a pure function of state so it never loops back from byte_vld.
    assign byte_rdy = (state_q == LEN0) || (state_q == LEN1) || (state_q == WORD);
    assign xfer     = byte_if.byte_vld && byte_rdy;

    // Full header value as seen while the high byte is on the bus.
    assign len_full = {byte_if.byte_dat, len_lo_q};

    assign pk_load  = xfer && (state_q == WORD);
    assign pk_clr   = (state_q == WRITE) || (state_q == IDLE);

    byte_packer u_packer (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (pk_clr),
        .load_i (pk_load),
        .byte_i (byte_if.byte_dat),
        .word_o (pk_word),
        .full_o (pk_full)
    );

    always_comb begin
        state_d  = state_q;
        waddr_d  = waddr_q;
        remain_d = remain_q;
        len_lo_d = len_lo_q;

        unique case (state_q)
            IDLE: begin
                // A byte offered alongside START is not taken: ready is low in IDLE.
                if (start_i) begin
                    state_d = LEN0;
                end
            end

            LEN0: begin
                if (xfer) begin
                    len_lo_d = byte_if.byte_dat;
                    state_d  = LEN1;
                end
            end

            LEN1: begin
                if (xfer) begin
                    if (len_full == '0) begin
                        state_d = FINISH;
                    end else if (32'(len_full) > MAX_WORDS_U) begin
                        state_d = ERROR;
                    end else begin
                        remain_d = len_full;
                        state_d  = WORD;
                    end
                end
            end

            WORD: begin
                if (pk_full) begin
                    state_d = WRITE;
                end
            end

            WRITE: begin
                // Address and count advance as the write cycle retires, so both
                // are stable while mem_wr is high.
                waddr_d  = waddr_q + ADDR_STEP;
                remain_d = remain_q - 1'b1;
                if (remain_q == LEN_W'(1)) begin
                    state_d = FINISH;
                end else begin
                    state_d = WORD;
                end
            end

            FINISH: state_d = FINISH;
            ERROR:  state_d = ERROR;

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            waddr_q  <= BASE_ADDR;
            remain_q <= '0;
            len_lo_q <= '0;
        end else begin
            state_q  <= state_d;
            waddr_q  <= waddr_d;
            remain_q <= remain_d;
            len_lo_q <= len_lo_d;
        end
    end

    assign byte_if.byte_rdy = byte_rdy;
    assign mem_if.mem_waddr = waddr_q;
    assign mem_if.mem_wdata = pk_word;
    assign mem_if.mem_wr    = (state_q == WRITE);

    // Decoded from registered state: the core stays held everywhere except FINISH,
    // including IDLE and ERROR, and is re-held the cycle a reset lands.
    assign cpu_hold_o = (state_q != FINISH);
    assign done_o     = (state_q == FINISH);
    assign err_o      = (state_q == ERROR);

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed self-checking bench for instr_mem_loader.
// Latency: n/a.
// Backpressure: bench drives byte_vld with optional idle gaps and obeys byte_rdy.
module tb_instr_mem_loader;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic cpu_hold;
    logic done;
    logic err;

    always #5 clk = ~clk;

    byte_stream_if bs ();
    imem_wr_if     mw ();

    instr_mem_loader dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .byte_if    (bs),
        .mem_if     (mw),
        .cpu_hold_o (cpu_hold),
        .done_o     (done),
        .err_o      (err)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Write log captured away from the active edge.
    logic [63:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];

    always @(negedge clk) begin
        if (mw.mem_wr === 1'b1) begin
            wr_addr_q.push_back(mw.mem_waddr);
            wr_data_q.push_back(mw.mem_wdata);
        end
    end

    logic [7:0] img [10];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; leaves the bench at a negedge with reset released.
    task automatic do_reset();
        rst_n       = 1'b0;
        start       = 1'b0;
        bs.byte_vld = 1'b0;
        bs.byte_dat = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one byte, wait for ready (bounded), then hold vld low for gap cycles.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int cnt;
        cnt         = 0;
        bs.byte_dat = b;
        bs.byte_vld = 1'b1;
        while (bs.byte_rdy !== 1'b1 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 50) begin
            check("rdy_timeout", {63'd0, bs.byte_rdy}, 64'd1);
        end
        @(negedge clk);
        bs.byte_vld = 1'b0;
        bs.byte_dat = 8'hxx;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_image(input int gap);
        for (int i = 0; i < 10; i++) begin
            send_byte(img[i], gap);
        end
    endtask

    // Expect exactly the two-word image written starting at log index base.
    task automatic check_image(input string tag, input int base);
        check({tag, "_wr_count"}, 64'(wr_addr_q.size()), 64'(base + 2));
        if (wr_addr_q.size() >= base + 2) begin
            check({tag, "_addr0"}, wr_addr_q[base],     64'h0);
            check({tag, "_data0"}, 64'(wr_data_q[base]),     64'h0000_0013);
            check({tag, "_addr1"}, wr_addr_q[base + 1], 64'h4);
            check({tag, "_data1"}, 64'(wr_data_q[base + 1]), 64'h0010_0093);
        end
    endtask

    initial begin
        int base;
        logic [31:0] w;
        logic [31:0] xor_exp;
        logic [31:0] xor_got;

        img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

        rst_n       = 1'b0;
        start       = 1'b0;
        bs.byte_vld = 1'b0;
        bs.byte_dat = 8'h00;
        @(negedge clk);

        // 1: reset values
        do_reset();
        check("rst_hold",  {63'd0, cpu_hold},     64'd1);
        check("rst_rdy",   {63'd0, bs.byte_rdy},  64'd0);
        check("rst_wr",    {63'd0, mw.mem_wr},    64'd0);
        check("rst_waddr", mw.mem_waddr,          64'h0);
        check("rst_wdata", 64'(mw.mem_wdata),     64'h0);
        check("rst_done",  {63'd0, done},         64'd0);
        check("rst_err",   {63'd0, err},          64'd0);

        // 2: back-to-back image; first header byte offered together with START
        base        = wr_addr_q.size();
        bs.byte_dat = img[0];
        bs.byte_vld = 1'b1;
        pulse_start();
        send_image(0);
        check("t2_wr_pulse", {63'd0, mw.mem_wr}, 64'd1);
        check("t2_hold_during_wr", {63'd0, cpu_hold}, 64'd1);
        @(negedge clk);
        check("t2_hold",  {63'd0, cpu_hold},    64'd0);
        check("t2_done",  {63'd0, done},        64'd1);
        check("t2_rdy",   {63'd0, bs.byte_rdy}, 64'd0);
        repeat (3) @(negedge clk);
        check_image("t2", base);

        // 3: same image with 3 idle cycles between bytes
        do_reset();
        base = wr_addr_q.size();
        pulse_start();
        send_image(3);
        repeat (2) @(negedge clk);
        check("t3_done", {63'd0, done}, 64'd1);
        check_image("t3", base);

        // 4a: zero-length image
        do_reset();
        base = wr_addr_q.size();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check("t4_zero_done", {63'd0, done},     64'd1);
        check("t4_zero_hold", {63'd0, cpu_hold}, 64'd0);
        repeat (2) @(negedge clk);
        check("t4_zero_wrs", 64'(wr_addr_q.size()), 64'(base));

        // 4b: N = MAX_WORDS+1 = 1025
        do_reset();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        check("t4_err",      {63'd0, err},         64'd1);
        check("t4_err_hold", {63'd0, cpu_hold},    64'd1);
        check("t4_err_rdy",  {63'd0, bs.byte_rdy}, 64'd0);
        check("t4_err_done", {63'd0, done},        64'd0);
        bs.byte_dat = 8'h55;
        bs.byte_vld = 1'b1;
        repeat (4) @(negedge clk);
        check("t4_err_rdy_late", {63'd0, bs.byte_rdy}, 64'd0);
        check("t4_err_no_wr",    64'(wr_addr_q.size()), 64'(base));
        bs.byte_vld = 1'b0;

        // 4c: N = MAX_WORDS is legal; word i = 0xA500_0000 | i
        do_reset();
        base    = wr_addr_q.size();
        xor_exp = '0;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        for (int i = 0; i < 1024; i++) begin
            w       = 32'hA500_0000 | 32'(i);
            xor_exp = xor_exp ^ w;
            for (int k = 0; k < 4; k++) begin
                send_byte(w[8*k +: 8], 0);
            end
        end
        repeat (2) @(negedge clk);
        check("t4_max_done",  {63'd0, done}, 64'd1);
        check("t4_max_err",   {63'd0, err},  64'd0);
        check("t4_max_count", 64'(wr_addr_q.size() - base), 64'd1024);
        if (wr_addr_q.size() == base + 1024) begin
            xor_got = '0;
            for (int i = 0; i < 1024; i++) begin
                xor_got = xor_got ^ wr_data_q[base + i];
            end
            check("t4_max_xor",   64'(xor_got), 64'(xor_exp));
            check("t4_max_addr0", wr_addr_q[base], 64'h0);
            check("t4_max_last_addr", wr_addr_q[base + 1023], 64'hFFC);
            check("t4_max_last_data", 64'(wr_data_q[base + 1023]), 64'hA500_03FF);
        end
        check("t4_max_waddr", mw.mem_waddr, 64'h1000);

        // 5: reset after 2 bytes of word 1, then a full reload
        do_reset();
        base = wr_addr_q.size();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h77, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t5_hold",  {63'd0, cpu_hold},    64'd1);
        check("t5_rdy",   {63'd0, bs.byte_rdy}, 64'd0);
        check("t5_waddr", mw.mem_waddr,         64'h0);
        check("t5_wdata", 64'(mw.mem_wdata),    64'h0);
        check("t5_done",  {63'd0, done},        64'd0);
        check("t5_no_wr", 64'(wr_addr_q.size()), 64'(base));
        pulse_start();
        send_image(0);
        repeat (2) @(negedge clk);
        check("t5_done2", {63'd0, done}, 64'd1);
        check_image("t5", base);

        // 6: START during WORD and after DONE is ignored
        do_reset();
        base = wr_addr_q.size();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        pulse_start();
        check("t6_word_rdy",   {63'd0, bs.byte_rdy}, 64'd1);
        check("t6_word_waddr", mw.mem_waddr,         64'h0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        repeat (2) @(negedge clk);
        check("t6_done",   {63'd0, done},          64'd1);
        check("t6_wr_cnt", 64'(wr_addr_q.size()),  64'(base + 1));
        if (wr_addr_q.size() == base + 1) begin
            check("t6_data", 64'(wr_data_q[base]), 64'h13);
        end
        pulse_start();
        @(negedge clk);
        check("t6_post_done",  {63'd0, done},        64'd1);
        check("t6_post_hold",  {63'd0, cpu_hold},    64'd0);
        check("t6_post_rdy",   {63'd0, bs.byte_rdy}, 64'd0);
        check("t6_post_waddr", mw.mem_waddr,         64'h4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
